// File: rtl/exec_pkg.sv
// Shared definitions for the parametrised execution unit: opcodes, flag bit
// positions and the control state encoding.
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;
  localparam logic [3:0] OP_LDI = 4'd11;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_S = 2;
  localparam int FLG_G = 3;
  localparam int FLG_V = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_WRITE
  } exec_state_t;

  function automatic logic is_arith(input logic [3:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_INC) || (opc == OP_DEC);
  endfunction

  // Codes above LDI are no-ops; CMP only produces flags.
  function automatic logic writes_rd(input logic [3:0] opc);
    return (opc <= OP_LDI) && (opc != OP_CMP);
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// Register file with an ALU and an external write port (ALU wins on a clash)
// and three combinational read ports.
module exec_regfile #(
  parameter int W    = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_waddr,
  input  logic [W-1:0]  alu_wdata,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_waddr,
  input  logic [W-1:0]  ext_wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  input  logic [AW-1:0] raddr_x,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b,
  output logic [W-1:0]  rdata_x
);

  logic [W-1:0] regs_q [NREG];

  // The ALU write is placed last so it overrides an external write to the same register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (ext_we) begin
        regs_q[ext_waddr] <= ext_wdata;
      end
      if (alu_we) begin
        regs_q[alu_waddr] <= alu_wdata;
      end
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign rdata_x = regs_q[raddr_x];

endmodule

// File: rtl/param_exec_unit.sv
// Parametrised execution unit: three-operand ALU, iterative shifter and flag
// register around exec_regfile, sequenced by a start/done control FSM.
module param_exec_unit
  import exec_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG),
  parameter int SW   = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic          use_imm,
  input  logic [W-1:0]  imm,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [4:0]    flags,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_waddr,
  input  logic [W-1:0]  ext_wdata,
  input  logic [AW-1:0] ext_raddr,
  output logic [W-1:0]  ext_rdata
);

  exec_state_t   state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [SW-1:0] k_q;
  logic [W:0]    res_q;
  logic          v_q, g_q, s_q, shifted_q;
  logic [W-1:0]  result_q;
  logic [4:0]    flags_q;
  logic          done_q;

  logic [W-1:0]  rdata_a, rdata_b, b_sel;
  logic [W:0]    alu_res;
  logic          alu_v, alu_g;
  logic          is_shift, alu_we;

  exec_regfile #(.W(W), .NREG(NREG), .AW(AW)) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .alu_we    (alu_we),
    .alu_waddr (rd_q),
    .alu_wdata (res_q[W-1:0]),
    .ext_we    (ext_we),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata),
    .raddr_a   (rs1),
    .raddr_b   (rs2),
    .raddr_x   (ext_raddr),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .rdata_x   (ext_rdata)
  );

  // LDI always takes the immediate, whatever use_imm says.
  assign b_sel    = (use_imm || (op == OP_LDI)) ? imm : rdata_b;
  assign is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);

  // Bit W of alu_res carries the carry-out, or the borrow for subtraction.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_g   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = {1'b0, a_q} + {1'b0, b_q};
        alu_v   = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        alu_res = {1'b0, a_q} - {1'b0, b_q};
        alu_v   = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_AND: alu_res = {1'b0, a_q & b_q};
      OP_OR:  alu_res = {1'b0, a_q | b_q};
      OP_XOR: alu_res = {1'b0, a_q ^ b_q};
      OP_CMP: begin
        alu_res = {1'b0, b_q - a_q};
        alu_g   = (a_q > b_q);
      end
      OP_INC: begin
        alu_res = {1'b0, a_q} + (W+1)'(1);
        alu_v   = !a_q[W-1] && alu_res[W-1];
      end
      OP_DEC: begin
        alu_res = {1'b0, a_q} - (W+1)'(1);
        alu_v   = a_q[W-1] && !alu_res[W-1];
      end
      OP_LDI:  alu_res = {1'b0, b_q};
      default: alu_res = {1'b0, a_q};
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    alu_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = (is_shift && (k_q != '0)) ? ST_SHIFT : ST_WRITE;
      end
      ST_SHIFT: begin
        if (k_q == SW'(1)) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        alu_we  = writes_rd(op_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, compute, one-bit-per-cycle shifting, commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      k_q       <= '0;
      res_q     <= '0;
      v_q       <= 1'b0;
      g_q       <= 1'b0;
      s_q       <= 1'b0;
      shifted_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == ST_WRITE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q       <= rdata_a;
            b_q       <= b_sel;
            op_q      <= op;
            rd_q      <= rd;
            k_q       <= b_sel[SW-1:0];
            shifted_q <= 1'b0;
          end
        end
        ST_EXEC: begin
          res_q <= is_shift ? {1'b0, a_q} : alu_res;
          v_q   <= alu_v;
          g_q   <= alu_g;
        end
        ST_SHIFT: begin
          if (op_q == OP_SHL) begin
            res_q <= {1'b0, res_q[W-2:0], 1'b0};
            s_q   <= res_q[W-1];
          end else begin
            res_q <= {2'b00, res_q[W-1:1]};
            s_q   <= res_q[0];
          end
          k_q       <= k_q - SW'(1);
          shifted_q <= 1'b1;
        end
        ST_WRITE: begin
          if (op_q <= OP_LDI) begin
            result_q       <= res_q[W-1:0];
            flags_q[FLG_Z] <= (res_q[W-1:0] == '0);
            if (is_arith(op_q)) begin
              flags_q[FLG_C] <= res_q[W];
              flags_q[FLG_V] <= v_q;
            end
            if (op_q == OP_CMP) begin
              flags_q[FLG_G] <= g_q;
            end
            if (shifted_q) begin
              flags_q[FLG_S] <= s_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE) || done_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_param_exec_unit.sv
// Self-checking bench for param_exec_unit (W=8, NREG=8): directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_param_exec_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] op;
  logic [2:0] rs1, rs2, rd;
  logic       use_imm;
  logic [7:0] imm;
  logic       busy, done;
  logic [7:0] result;
  logic [4:0] flags;
  logic       ext_we;
  logic [2:0] ext_waddr;
  logic [7:0] ext_wdata;
  logic [2:0] ext_raddr;
  logic [7:0] ext_rdata;

  int         check_count = 0;
  int         pass_count  = 0;
  int         model_regs [8];
  logic [4:0] model_flags;
  int         model_result;

  param_exec_unit #(.W(8), .NREG(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .use_imm   (use_imm),
    .imm       (imm),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags     (flags),
    .ext_we    (ext_we),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata),
    .ext_raddr (ext_raddr),
    .ext_rdata (ext_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  task automatic checkReg(input string tag, input int addr);
    ext_raddr = 3'(addr);
    #1;
    checkOutput(tag, ext_rdata, model_regs[addr]);
  endtask

  task automatic extWrite(input int addr, input int data);
    ext_we    = 1'b1;
    ext_waddr = 3'(addr);
    ext_wdata = 8'(data);
    @(posedge clock);
    #1;
    ext_we = 1'b0;
    model_regs[addr] = data & 255;
  endtask

  // Issues one operation, waits for done, and compares against the model.
  // collide: external write to rd on the commit edge; poke: stray start while shifting.
  task automatic applyStimulus(input int opc, input int s1, input int s2, input int d,
                               input bit ui, input int im, input bit collide, input bit poke);
    int a, b, k, r, sv, n, lat, poke_reg;
    bit wr, noop, do_collide, do_poke;
    logic [4:0] f;
    a = model_regs[s1];
    b = ((opc == 11) || ui) ? (im & 255) : model_regs[s2];
    f = model_flags;
    r = 0; k = 0; wr = 1; noop = 0;
    case (opc)
      0: begin r = a + b; f[1] = (r > 255); sv = sgn(a) + sgn(b); f[4] = (sv > 127) || (sv < -128); end
      1: begin r = a - b; f[1] = (a < b);   sv = sgn(a) - sgn(b); f[4] = (sv > 127) || (sv < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin k = b % 8; r = a << k; if (k > 0) f[2] = ((a >> (8 - k)) & 1) != 0; end
      6: begin k = b % 8; r = a >> k; if (k > 0) f[2] = ((a >> (k - 1)) & 1) != 0; end
      7: begin r = b - a; f[3] = (a > b); wr = 0; end
      8: begin r = a + 1; f[1] = (r > 255); f[4] = (sgn(a) + 1 > 127); end
      9: begin r = a - 1; f[1] = (a == 0);  f[4] = (sgn(a) - 1 < -128); end
      10: r = a;
      11: r = b;
      default: begin noop = 1; wr = 0; end
    endcase
    r = r & 255;
    if (!noop) f[0] = (r == 0);
    lat        = 2 + k;
    do_collide = collide && wr;
    do_poke    = poke && (k >= 3);
    poke_reg   = (d + 1) % 8;

    start   = 1'b1;
    op      = 4'(opc);
    rs1     = 3'(s1);
    rs2     = 3'(s2);
    rd      = 3'(d);
    use_imm = ui;
    imm     = 8'(im);
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    while (1) begin
      @(posedge clock);
      #1;
      n++;
      start  = 1'b0;
      ext_we = 1'b0;
      if (n == 1) checkOutput("busy_after_accept", busy, 1);
      if (done || n >= 40) break;
      if (do_collide && n == lat - 1) begin
        ext_we = 1'b1; ext_waddr = 3'(d); ext_wdata = 8'h5A;
      end
      if (do_poke && n == 1) begin
        start = 1'b1; op = 4'd11; rd = 3'(poke_reg); imm = 8'h33;
      end
    end
    checkOutput("done_seen", done, 1);
    checkOutput("latency", n, lat);
    checkOutput("busy_in_done", busy, 1);

    if (wr) model_regs[d] = r;
    if (!noop) model_result = r;
    model_flags = f;
    checkOutput("result", result, model_result);
    checkOutput("flags", flags, model_flags);
    checkReg("reg_rd", d);
    if (do_poke) checkReg("poke_ignored", poke_reg);
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    use_imm = 1'b0; imm = '0; ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0; ext_raddr = '0;
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_flags  = '0;
    model_result = 0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_flags", flags, 0);
    checkReg("rst_reg3", 3);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] directed cases");
    extWrite(1, 200);
    extWrite(2, 100);
    checkReg("load_reg1", 1);
    applyStimulus(0, 1, 2, 3, 0, 0, 0, 0);
    checkOutput("plan_add_result", result, 8'h2C);
    checkOutput("plan_add_czv", {flags[4], flags[1], flags[0]}, 3'b010);

    extWrite(4, 8'h7F);
    applyStimulus(0, 4, 0, 5, 1, 1, 0, 0);
    checkOutput("plan_ovf_result", result, 8'h80);
    checkOutput("plan_ovf_vc", {flags[4], flags[1]}, 2'b10);

    extWrite(6, 8'hFF);
    applyStimulus(8, 6, 0, 6, 0, 0, 0, 0);
    checkOutput("plan_inc_zc", {flags[1], flags[0]}, 2'b11);

    extWrite(1, 9);
    extWrite(2, 3);
    extWrite(7, 8'h44);
    applyStimulus(7, 1, 2, 7, 0, 0, 0, 0);
    checkOutput("plan_cmp_gz", {flags[3], flags[0]}, 2'b10);

    extWrite(4, 5);
    applyStimulus(1, 4, 0, 5, 1, 5, 0, 0);
    checkOutput("plan_sub_gcz", {flags[3], flags[1], flags[0]}, 3'b101);

    extWrite(1, 8'hE0);
    applyStimulus(5, 1, 0, 2, 1, 3, 0, 1);
    checkOutput("plan_shl_sz", {flags[2], flags[0]}, 2'b11);

    extWrite(3, 8'h81);
    applyStimulus(6, 3, 0, 4, 1, 0, 1, 0);
    checkOutput("plan_shr0_result", result, 8'h81);
    checkOutput("plan_shr0_s", flags[2], 1);

    applyStimulus(13, 1, 2, 3, 0, 0, 0, 0);

    $display("[TB] randomized operations");
    for (int t = 0; t < 150; t++) begin
      int opc;
      if ($urandom_range(0, 3) == 0) extWrite($urandom_range(0, 7), $urandom_range(0, 255));
      opc = $urandom_range(0, 15);
      applyStimulus(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), $urandom_range(0, 255),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during shift");
    extWrite(1, 8'hA5);
    start = 1'b1; op = 4'd5; rs1 = 3'd1; rd = 3'd2; use_imm = 1'b1; imm = 8'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_flags  = '0;
    model_result = 0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_flags", flags, 0);
    checkReg("abort_reg1", 1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);
    checkReg("abort_reg2", 2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
